// File: rtl/ncpu32k_ifq_if.sv
// rtl/ncpu32k_ifq_if.sv - IFU-to-queue and queue-to-decode handshake bundle
interface ncpu32k_ifq_if #(
  parameter int AW = 32,
  parameter int IW = 32
);
  // IFU side
  logic          ifu_valid;
  logic          ifu_ready;
  logic [IW-1:0] ifu_insn;
  logic [AW-1:0] ifu_pc;
  logic          ifu_EITM;
  logic          ifu_EIPF;

  // Decode side
  logic          idu_valid;
  logic          idu_ready;
  logic [IW-1:0] idu_insn;
  logic [AW-1:0] idu_pc;
  logic          idu_EITM;
  logic          idu_EIPF;
  logic          idu_EIRQ;

  // Environment view: IFU producer plus decode consumer
  modport master (
    output ifu_valid, ifu_insn, ifu_pc, ifu_EITM, ifu_EIPF, idu_ready,
    input  ifu_ready, idu_valid, idu_insn, idu_pc, idu_EITM, idu_EIPF, idu_EIRQ
  );

  // Queue view
  modport slave (
    input  ifu_valid, ifu_insn, ifu_pc, ifu_EITM, ifu_EIPF, idu_ready,
    output ifu_ready, idu_valid, idu_insn, idu_pc, idu_EITM, idu_EIPF, idu_EIRQ
  );
endinterface

// File: rtl/ncpu32k_ifq.sv
// rtl/ncpu32k_ifq.sv - instruction fetch queue between IFU and decode
module ncpu32k_ifq #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     irq_sync,
  ncpu32k_ifq_if.slave             bus,
  output logic [$clog2(DEPTH):0]   ifq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IW-1:0] insn;
    logic [AW-1:0] pc;
    logic          eitm;
    logic          eipf;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  // Ready depends only on registered occupancy, never on idu_ready
  assign bus.ifu_ready = (cnt != CW'(DEPTH));
  assign bus.idu_valid = (cnt != '0);

  assign push = bus.ifu_valid & bus.ifu_ready & ~flush;
  assign pop  = bus.idu_valid & bus.idu_ready & ~flush;

  // Pointer and occupancy update; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents survive flush and reset, only pointers move
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= '{insn: bus.ifu_insn, pc: bus.ifu_pc,
                   eitm: bus.ifu_EITM, eipf: bus.ifu_EIPF};
    end
  end

  // Head is masked to zero when empty so decode sees a NOP
  always_comb begin
    head = '0;
    if (bus.idu_valid) head = mem[rp];
  end

  assign bus.idu_insn = head.insn;
  assign bus.idu_pc   = head.pc;
  assign bus.idu_EITM = head.eitm;
  assign bus.idu_EIPF = head.eipf;
  assign bus.idu_EIRQ = irq_sync & bus.idu_valid;
  assign ifq_count    = cnt;

`ifdef NCPU_ENABLE_ASSERT
  a_cnt_range:  assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(DEPTH));
  a_no_ovf:     assert property (@(posedge clk) disable iff (!rst_n) push |-> (cnt != CW'(DEPTH)));
  a_no_udf:     assert property (@(posedge clk) disable iff (!rst_n) pop |-> (cnt != '0));
  a_depth_pow2: assert property (@(posedge clk) ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= 2));
`endif

endmodule
